game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Central game-flow controller for the frogger design. It sequences play through five phases: attract, playing, hit pause, level-clear pause and game over. It owns the level and lives registers and drives the frog-reset pulse. It also drives a freeze signal that halts car movement, plus a blink flag for the VGA renderer. It sits between the frog controller, which supplies collision and reached-top events, and the car, level-display and VGA blocks, which consume level, lives, freeze and flash.

Parameters:
PAUSE_TICKS, 25000000, length of the HIT and CLEAR pauses in i_Clk cycles (1 s at 25 MHz); must be >= 2.
START_LIVES, 3, lives loaded on game start; range 1..3.
MAX_LEVEL, 9, highest level; level saturates here.
BLINK_BIT, 22, timer bit that drives o_Flash during pauses.

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Start  in  1  debounced start/restart request (all four switches held), level signal
i_Collision  in  1  frog overlaps a car, level signal
i_Frog_At_Top  in  1  frog reached goal row, level signal
o_State  out  3  current state encoding (debug/VGA overlay)
o_Freeze  out  1  1 = cars and frog input halted
o_Reset_Frog  out  1  one-cycle pulse that returns the frog to its start cell
o_Level  out  4  current level, 1..MAX_LEVEL
o_Lives  out  2  remaining lives, 0..START_LIVES
o_Flash  out  1  blink flag for the renderer
o_Game_Over  out  1  high while in OVER

Behaviour:
- Inputs are synchronous to i_Clk. Each input is rising-edge detected against a registered copy; edge registers clear on reset. All outputs are registered, so an event edge in cycle N produces its response in cycle N+1.
- Reset values: state IDLE, o_Freeze 1, o_Reset_Frog 0, o_Level 1, o_Lives START_LIVES, o_Flash 0, o_Game_Over 0, timer 0.
- State encodings: IDLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4; other codes fall to IDLE.
- IDLE: freeze 1. A start edge loads level 1 and lives START_LIVES, pulses o_Reset_Frog and moves to PLAY.
- PLAY: freeze 0.
  - Collision edge with lives > 1: decrement lives, load timer with PAUSE_TICKS-1, go to HIT.
  - Collision edge with lives == 1: set lives 0, go to OVER.
  - Frog-at-top edge: load timer, go to CLEAR.
- HIT: freeze 1; timer decrements each cycle. When the timer is 0, pulse o_Reset_Frog and return to PLAY. The pause is PAUSE_TICKS cycles.
- CLEAR: same timing as HIT. On expiry, level increments (saturates at MAX_LEVEL), o_Reset_Frog pulses and the state returns to PLAY. Lives are unchanged.
- OVER: freeze 1 and o_Game_Over 1; level and lives hold. A start edge restarts exactly as from IDLE.
- o_Flash = timer[BLINK_BIT] in HIT and CLEAR; 1 in OVER; 0 otherwise.
- Priority for same-cycle events: start edge > collision edge > frog-at-top edge.
- A start edge in any state performs a full restart: level 1, lives START_LIVES, reset pulse, PLAY, timer cleared.
- A held level signal never re-triggers. Events other than start are ignored outside PLAY.
- Reset asserted mid-pause clears the timer immediately. No o_Reset_Frog pulse is emitted on reset.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE..ST_OVER);
  - START_LIVES and MAX_LEVEL defaults;
  - level/lives widths, reused by the level-display and VGA blocks.
- One natural sub-module, pause_timer: loadable down-counter with a done flag, clog2(PAUSE_TICKS) bits wide, with the same clock and reset.

Test Plan:
PAUSE_TICKS=10, BLINK_BIT=1 for all cases.
1. Reset, then start edge -> one-cycle o_Reset_Frog, o_State 1, o_Freeze 0, level 1, lives 3.
2. In PLAY, collision edge -> HIT, lives 2, freeze 1 for exactly 10 cycles; reset pulse on the 11th; back in PLAY. Holding collision high afterwards produces no second hit.
3. Three separate collisions from start -> lives 2, 1, then 0 with OVER and o_Game_Over 1 after the third. A later start edge -> PLAY, lives 3, level 1.
4. Frog-at-top edge repeated 10 times, each followed by a 10-cycle pause -> level 1 through 9, then held at 9; lives unchanged.
5. Collision and frog-at-top asserted in the same cycle -> HIT and lives decremented; level unchanged.
6. Reset asserted 5 cycles into a CLEAR pause -> IDLE immediately, freeze 1, level 1, no reset pulse. Start edge during HIT -> immediate restart with lives 3.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_pkg
// Description : Shared definitions for the frogger game-flow controller:
//               state encoding, level/lives widths and default limits.
//               The widths are also consumed by the level-display and VGA
//               blocks so every block agrees on bus sizes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package game_sequencer_pkg;

  localparam int STATE_W         = 3;
  localparam int LEVEL_W         = 4;
  localparam int LIVES_W         = 2;
  localparam int DEF_START_LIVES = 3;
  localparam int DEF_MAX_LEVEL   = 9;

  // Encodings are visible on o_State, so the values are fixed explicitly.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Level advance that sticks at the top level instead of wrapping.
  function automatic logic [LEVEL_W-1:0] level_inc(
    input logic [LEVEL_W-1:0] lvl,
    input logic [LEVEL_W-1:0] max_lvl
  );
    return (lvl >= max_lvl) ? max_lvl : lvl + LEVEL_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_if
// Description : Event inputs and game-state outputs of the game sequencer.
// Ports       : i_Start, i_Collision, i_Frog_At_Top  - level event inputs
//               o_State, o_Freeze, o_Reset_Frog,
//               o_Level, o_Lives, o_Flash, o_Game_Over - game-state outputs
//               modport master : event source / state consumer
//               modport slave  : the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;
  import game_sequencer_pkg::*;

  logic               i_Start;
  logic               i_Collision;
  logic               i_Frog_At_Top;
  logic [STATE_W-1:0] o_State;
  logic               o_Freeze;
  logic               o_Reset_Frog;
  logic [LEVEL_W-1:0] o_Level;
  logic [LIVES_W-1:0] o_Lives;
  logic               o_Flash;
  logic               o_Game_Over;

  modport master (
    output i_Start, i_Collision, i_Frog_At_Top,
    input  o_State, o_Freeze, o_Reset_Frog, o_Level, o_Lives, o_Flash, o_Game_Over
  );

  modport slave (
    input  i_Start, i_Collision, i_Frog_At_Top,
    output o_State, o_Freeze, o_Reset_Frog, o_Level, o_Lives, o_Flash, o_Game_Over
  );

endinterface
`default_nettype wire

// File: rtl/game_sequencer_pause_timer.sv
`default_nettype none
// ============================================================================
// Module      : pause_timer
// Description : Loadable down-counter timing the HIT and CLEAR pauses.
//               Load sets PAUSE_TICKS-1, clear forces zero, enable counts
//               down and stops at zero.
// Ports       : i_Clk, i_Rst_n        - clock, async active-low reset
//               i_Load, i_Clear, i_En - counter controls (load wins)
//               o_Done                - counter is zero
//               o_Blink               - counter bit BLINK_BIT
// Revision    : 1.0 - initial release
// ============================================================================
module pause_timer #(
  parameter int PAUSE_TICKS = 25000000,
  parameter int BLINK_BIT   = 22
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Load,
  input  logic i_Clear,
  input  logic i_En,
  output logic o_Done,
  output logic o_Blink
);

  localparam int c_TMR_W = $clog2(PAUSE_TICKS);

  logic [c_TMR_W-1:0] r_count;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count <= '0;
    end else if (i_Load) begin
      r_count <= c_TMR_W'(PAUSE_TICKS - 1);
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (i_En && (r_count != '0)) begin
      r_count <= r_count - c_TMR_W'(1);
    end
  end

  assign o_Done = (r_count == '0);

  // Small PAUSE_TICKS values may leave no counter bit at BLINK_BIT.
  generate
    if (BLINK_BIT < c_TMR_W) begin : g_blink_bit
      assign o_Blink = r_count[BLINK_BIT];
    end else begin : g_blink_none
      assign o_Blink = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Frogger game-flow controller. Sequences attract, play, hit
//               pause, level-clear pause and game-over; owns level and lives;
//               pulses the frog reset; freezes play and drives a blink flag.
// Ports       : i_Clk   - system clock
//               i_Rst_n - asynchronous active-low reset
//               io_Bus  - game_sequencer_if.slave (events in, state out)
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int PAUSE_TICKS = 25000000,
  parameter int START_LIVES = DEF_START_LIVES,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int BLINK_BIT   = 22
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  game_sequencer_if.slave io_Bus
);

  logic               r_start_d, r_coll_d, r_top_d;
  logic               w_start_edge, w_coll_edge, w_top_edge;
  state_t             r_state, w_state_nxt;
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic               r_reset_frog, w_reset_frog_nxt;
  logic               w_tmr_load, w_tmr_clear, w_tmr_en;
  logic               w_tmr_done, w_tmr_blink;
  logic               w_flash;

  // Edge detectors run in every state so a level held across a state change
  // can never fire later.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_start_d <= 1'b0;
      r_coll_d  <= 1'b0;
      r_top_d   <= 1'b0;
    end else begin
      r_start_d <= io_Bus.i_Start;
      r_coll_d  <= io_Bus.i_Collision;
      r_top_d   <= io_Bus.i_Frog_At_Top;
    end
  end

  assign w_start_edge = io_Bus.i_Start       & ~r_start_d;
  assign w_coll_edge  = io_Bus.i_Collision   & ~r_coll_d;
  assign w_top_edge   = io_Bus.i_Frog_At_Top & ~r_top_d;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state      <= ST_IDLE;
      r_level      <= LEVEL_W'(1);
      r_lives      <= LIVES_W'(START_LIVES);
      r_reset_frog <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_lives      <= w_lives_nxt;
      r_reset_frog <= w_reset_frog_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_level_nxt      = r_level;
    w_lives_nxt      = r_lives;
    w_reset_frog_nxt = 1'b0;
    w_tmr_load       = 1'b0;
    w_tmr_clear      = 1'b0;
    w_tmr_en         = 1'b0;

    // Start restarts the game from any state and outranks all other events.
    if (w_start_edge) begin
      w_state_nxt      = ST_PLAY;
      w_level_nxt      = LEVEL_W'(1);
      w_lives_nxt      = LIVES_W'(START_LIVES);
      w_reset_frog_nxt = 1'b1;
      w_tmr_clear      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_PLAY: begin
          if (w_coll_edge) begin
            if (r_lives > LIVES_W'(1)) begin
              w_lives_nxt = r_lives - LIVES_W'(1);
              w_tmr_load  = 1'b1;
              w_state_nxt = ST_HIT;
            end else begin
              w_lives_nxt = '0;
              w_state_nxt = ST_OVER;
            end
          end else if (w_top_edge) begin
            w_tmr_load  = 1'b1;
            w_state_nxt = ST_CLEAR;
          end
        end
        ST_HIT, ST_CLEAR: begin
          // The timer sits at PAUSE_TICKS-1 on entry, so expiring on zero
          // gives a pause of exactly PAUSE_TICKS cycles.
          if (w_tmr_done) begin
            if (r_state == ST_CLEAR) begin
              w_level_nxt = level_inc(r_level, LEVEL_W'(MAX_LEVEL));
            end
            w_reset_frog_nxt = 1'b1;
            w_state_nxt      = ST_PLAY;
          end else begin
            w_tmr_en = 1'b1;
          end
        end
        ST_OVER: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  pause_timer #(
    .PAUSE_TICKS (PAUSE_TICKS),
    .BLINK_BIT   (BLINK_BIT)
  ) u_pause_timer (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Load  (w_tmr_load),
    .i_Clear (w_tmr_clear),
    .i_En    (w_tmr_en),
    .o_Done  (w_tmr_done),
    .o_Blink (w_tmr_blink)
  );

  // Status outputs decode registers only, so they change one cycle after
  // the triggering event edge.
  always_comb begin
    w_flash = 1'b0;
    case (r_state)
      ST_HIT, ST_CLEAR: w_flash = w_tmr_blink;
      ST_OVER:          w_flash = 1'b1;
      default:          w_flash = 1'b0;
    endcase
  end

  assign io_Bus.o_State      = r_state;
  assign io_Bus.o_Freeze     = (r_state != ST_PLAY);
  assign io_Bus.o_Reset_Frog = r_reset_frog;
  assign io_Bus.o_Level      = r_level;
  assign io_Bus.o_Lives      = r_lives;
  assign io_Bus.o_Flash      = w_flash;
  assign io_Bus.o_Game_Over  = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer (PAUSE_TICKS=10,
//               BLINK_BIT=1): fixed vector table, directed corner sequences
//               and random events compared against a behavioural model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  localparam int TB_PAUSE = 10;
  localparam int TB_BLINK = 1;
  localparam int TB_LIVES = 3;
  localparam int TB_MAX   = 9;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_HIT   = 2;
  localparam int M_CLEAR = 3;
  localparam int M_OVER  = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  game_sequencer_if u_if ();

  game_sequencer #(
    .PAUSE_TICKS (TB_PAUSE),
    .START_LIVES (TB_LIVES),
    .MAX_LEVEL   (TB_MAX),
    .BLINK_BIT   (TB_BLINK)
  ) u_dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .io_Bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {state[3], freeze, reset_frog, level[4], lives[2], flash, over}
  function automatic logic [12:0] ep(int st, bit frz, bit pul, int lvl, int liv, bit fl, bit ov);
    logic [2:0] s3;
    logic [3:0] l4;
    logic [1:0] v2;
    s3 = st[2:0];
    l4 = lvl[3:0];
    v2 = liv[1:0];
    return {s3, frz, pul, l4, v2, fl, ov};
  endfunction

  task automatic check(string name, logic [12:0] exp);
    logic [12:0] act;
    act = {u_if.o_State, u_if.o_Freeze, u_if.o_Reset_Frog, u_if.o_Level,
           u_if.o_Lives, u_if.o_Flash, u_if.o_Game_Over};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got st=%0d frz=%b rf=%b lvl=%0d liv=%0d fl=%b ov=%b, want st=%0d frz=%b rf=%b lvl=%0d liv=%0d fl=%b ov=%b",
               name, $time, act[12:10], act[9], act[8], act[7:4], act[3:2], act[1], act[0],
               exp[12:10], exp[9], exp[8], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_mode, m_level, m_lives, m_left;
  bit m_pulse, m_ps, m_pc, m_pt;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_level = 1;
    m_lives = TB_LIVES;
    m_left  = 0;
    m_pulse = 0;
    m_ps = 0; m_pc = 0; m_pt = 0;
  endtask

  // m_left counts the pause cycles still to spend, including the current one.
  task automatic model_step(bit s, bit c, bit t);
    bit se, ce, te;
    se = s & ~m_ps;
    ce = c & ~m_pc;
    te = t & ~m_pt;
    m_pulse = 0;
    if (se) begin
      m_mode = M_PLAY; m_level = 1; m_lives = TB_LIVES; m_pulse = 1; m_left = 0;
    end else if (m_mode == M_PLAY) begin
      if (ce) begin
        if (m_lives > 1) begin
          m_lives--; m_mode = M_HIT; m_left = TB_PAUSE;
        end else begin
          m_lives = 0; m_mode = M_OVER;
        end
      end else if (te) begin
        m_mode = M_CLEAR; m_left = TB_PAUSE;
      end
    end else if (m_mode == M_HIT || m_mode == M_CLEAR) begin
      if (m_left == 1) begin
        if (m_mode == M_CLEAR && m_level < TB_MAX) m_level++;
        m_pulse = 1; m_mode = M_PLAY; m_left = 0;
      end else begin
        m_left--;
      end
    end
    m_ps = s; m_pc = c; m_pt = t;
  endtask

  function automatic logic [12:0] model_exp();
    bit fl;
    fl = 0;
    if (m_mode == M_HIT || m_mode == M_CLEAR) fl = (((m_left - 1) >> TB_BLINK) & 1) != 0;
    else if (m_mode == M_OVER) fl = 1;
    return ep(m_mode, m_mode != M_PLAY, m_pulse, m_level, m_lives, fl, m_mode == M_OVER);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit s, bit c, bit t);
    u_if.i_Start       = s;
    u_if.i_Collision   = c;
    u_if.i_Frog_At_Top = t;
  endtask

  task automatic drv(bit s, bit c, bit t, string name);
    set_in(s, c, t);
    tick();
    model_step(s, c, t);
    check(name, model_exp());
  endtask

  task automatic do_reset();
    set_in(0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          s, c, t;
    int          cyc;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit s, bit c, bit t, int cyc, logic [12:0] exp, string name);
    vec_t v;
    v.s = s; v.c = c; v.t = t; v.cyc = cyc; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    set_in(0, 0, 0);
    #2;

    // ---------------- fixed vector table ----------------
    add(0,0,0, 1, ep(0,1,0,1,3,0,0), "reset_idle");
    add(1,0,0, 1, ep(1,0,1,1,3,0,0), "start");
    add(1,0,0, 1, ep(1,0,0,1,3,0,0), "start_held");
    add(0,1,0, 1, ep(2,1,0,1,2,0,0), "hit_enter");
    add(0,1,0, 7, ep(2,1,0,1,2,1,0), "hit_mid_flash");
    add(0,1,0, 2, ep(2,1,0,1,2,0,0), "hit_last_cycle");
    add(0,1,0, 1, ep(1,0,1,1,2,0,0), "hit_exit_pulse");
    add(0,1,0, 3, ep(1,0,0,1,2,0,0), "coll_held_no_retrigger");
    add(0,0,1, 1, ep(3,1,0,1,2,0,0), "clear_enter");
    add(0,0,0,10, ep(1,0,1,2,2,0,0), "clear_exit_level2");
    add(0,1,1, 1, ep(2,1,0,2,1,0,0), "coll_beats_top");
    add(0,0,0,10, ep(1,0,1,2,1,0,0), "hit2_exit");
    add(0,1,0, 1, ep(4,1,0,2,0,1,1), "last_life_over");
    add(0,0,0, 3, ep(4,1,0,2,0,1,1), "over_hold");
    add(1,0,0, 1, ep(1,0,1,1,3,0,0), "restart_from_over");
    add(0,0,1, 1, ep(3,1,0,1,3,0,0), "clear2_enter");
    add(0,0,0, 6, ep(3,1,0,1,3,1,0), "clear2_mid_flash");
    add(1,0,0, 1, ep(1,0,1,1,3,0,0), "start_in_clear");

    do_reset();
    foreach (tbl[i]) begin
      set_in(tbl[i].s, tbl[i].c, tbl[i].t);
      repeat (tbl[i].cyc) tick();
      check(tbl[i].name, tbl[i].exp);
    end

    // ---------------- reset asserted mid CLEAR pause ----------------
    do_reset();
    drv(1, 0, 0, "a_start");
    drv(0, 0, 1, "a_clear");
    for (int i = 0; i < 4; i++) drv(0, 0, 0, "a_pause");
    rst_n = 1'b0;
    #2;
    check("rst_mid_clear", ep(0,1,0,1,3,0,0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(0, 0, 0, "a_post_rst");
    check("post_rst_no_pulse", ep(0,1,0,1,3,0,0));

    // ---------------- level saturation ----------------
    do_reset();
    drv(1, 0, 0, "b_start");
    drv(0, 0, 0, "b_release");
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 1, "b_top");
      for (int k = 0; k < TB_PAUSE; k++) drv(0, 0, 0, "b_pause");
    end
    drv(0, 0, 0, "b_settle");
    check("level_saturated", ep(1,0,0,9,3,0,0));

    // ---------------- start during HIT ----------------
    do_reset();
    drv(1, 0, 0, "c_start");
    drv(0, 1, 0, "c_hit");
    for (int i = 0; i < 3; i++) drv(0, 0, 0, "c_pause");
    drv(1, 0, 0, "c_restart");
    check("start_in_hit", ep(1,0,1,1,3,0,0));

    // ---------------- randomized events vs model ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 20, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
